serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial, LSB-first unsigned adder with a start/done handshake. It is the addition-side counterpart to the team's combinational subtractor cells. It trades area for latency: one full-adder slice plus a carry flip-flop processes one bit per clock. It sits beside the arithmetic cells as the building block for multi-cycle datapaths.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when idle or in the DONE cycle.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse; sum and cout valid.
- sum  output  WIDTH  result (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch a into shift register A, b into shift register B, and cin into the carry flip-flop.
  - Clear the bit counter; next state is RUN.
  - On start=0, remain in IDLE.
- RUN, once per cycle:
  - full_adder(A[0], B[0], carry) produces s and c.
  - Shift A and B right by one.
  - Shift s into sum at the MSB (sum shifts right).
  - carry <= c; counter increments.
- RUN exit: when counter == WIDTH-1 at the edge, that edge processes the final bit and the next state is DONE.
- DONE:
  - done=1; cout = carry; sum holds the final result.
  - start=1 is accepted exactly as in IDLE, and the next state is RUN (back-to-back operation).
  - Otherwise the next state is IDLE.
- start while in RUN is ignored: no relatch, no restart.
- sum and cout:
  - Hold their values in IDLE until the next accepted start.
  - During RUN, sum shows partial contents and is not valid.
- The counter is $clog2(WIDTH) bits wide and never wraps inside one operation.
- Arithmetic is unsigned. Overflow is reported only through cout, with no saturation.

## Timing
- Reset (rst=1 at an edge) forces the following, regardless of state:
  - state=IDLE, busy=0, done=0.
  - sum=0, cout=0, carry=0, counter=0.
  - A and B registers cleared.
- Reset mid-RUN aborts the operation. No done pulse follows.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Latency: start accepted at edge k gives busy=1 in the cycles after edges k .. k+WIDTH-1.
- done=1 for exactly one cycle, after edge k+WIDTH, and the result is valid in that cycle.
- Throughput with back-to-back starts: one result per WIDTH+1 cycles.
- busy and done are never high simultaneously.
- rst and start asserted together: rst wins.

## Structure
- A shared package serial_arith_pkg holds:
  - the state typedef/localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - the WIDTH range limits used for the elaboration check.
- Sub-module full_adder (a, b, cin -> sum, cout) is purely combinational and instantiated once. It is the single bit slice.
- The top level holds the FSM, the counter, and the A/B/sum shift registers plus the carry flip-flop.

## Test plan
- WIDTH=4, a=5, b=3, cin=0 -> busy for 4 cycles, then a done pulse with sum=8, cout=0.
- WIDTH=4, a=15, b=1, cin=0 -> sum=0, cout=1. Then a=0, b=0, cin=1 -> sum=1, cout=0.
- WIDTH=8, a=255, b=255, cin=1 -> sum=255, cout=1. With cin=0 -> sum=254, cout=1.
- Start a=2, b=2; pulse start with a=7, b=7 during cycle 2 of RUN -> ignored; result sum=4, and done is still exactly WIDTH cycles after the first start.
- Assert rst in cycle 2 of RUN -> next cycle busy=0, done=0, sum=0, cout=0. No done pulse appears for 2·WIDTH cycles.
- Back-to-back: hold start=1 through the DONE cycle with new operands (a=1, b=2) -> first result seen, then busy rises the next cycle, and the second done shows sum=3 WIDTH+1 cycles after the first done.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM encoding and width limits for the bit-serial arithmetic blocks
package serial_arith_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;
endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: single-bit combinational adder slice
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial unsigned adder with start/done handshake
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_s, w_c, w_accept, w_last;

    full_adder u_fa (.a(r_a[0]), .b(r_b[0]), .cin(r_carry), .sum(w_s), .cout(w_c));

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == RUN) ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
    end

    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
        sum  = r_sum;
        cout = r_carry;
    end

    // counter saturates on the last bit so it never wraps for power-of-two widths
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_carry <= w_c;
            r_cnt   <= w_last ? r_cnt : r_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed scenario bench for serial_adder at WIDTH=4 and WIDTH=8
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
                                    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));
    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
                                    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                       input logic [3:0] es, input logic ec, input string nm);
        a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                errors++;
                $display("FAIL %s run%0d: busy=%b done=%b, required busy=1 done=0", nm, i, busy4, done4);
            end
            tick();
        end
        checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: busy=%b done=%b, required busy=0 done=1", nm, busy4, done4);
        end
        checks++;
        if (sum4 !== es || cout4 !== ec) begin
            errors++;
            $display("FAIL %s result: sum=%0d cout=%b, required sum=%0d cout=%b", nm, sum4, cout4, es, ec);
        end
        tick();
        checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b0 || sum4 !== es || cout4 !== ec) begin
            errors++;
            $display("FAIL %s idle_hold: done=%b busy=%b sum=%0d cout=%b, required done=0 busy=0 sum=%0d cout=%b",
                     nm, done4, busy4, sum4, cout4, es, ec);
        end
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [7:0] es, input logic ec, input string nm);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL %s run%0d: busy=%b done=%b, required busy=1 done=0", nm, i, busy8, done8);
            end
            tick();
        end
        checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || sum8 !== es || cout8 !== ec) begin
            errors++;
            $display("FAIL %s result: done=%b busy=%b sum=%0d cout=%b, required done=1 busy=0 sum=%0d cout=%b",
                     nm, done8, busy8, sum8, cout8, es, ec);
        end
        tick();
        checks++;
        if (done8 !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: done=%b, required 0", nm, done8);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start4 = 1'b1; start8 = 1'b1; a4 = 4'd9; b4 = 4'd9; a8 = 8'd9; b8 = 8'd9;
        tick();
        tick();
        start4 = 1'b0; start8 = 1'b0;
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 4'd0 || cout4 !== 1'b0) begin
            errors++;
            $display("FAIL reset4: busy=%b done=%b sum=%0d cout=%b, required all 0", busy4, done4, sum4, cout4);
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'd0 || cout8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b sum=%0d cout=%b, required all 0", busy8, done8, sum8, cout8);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy4, done4);
        end
    endtask

    task automatic test_basic();
        op4(4'd5, 4'd3, 1'b0, 4'd8, 1'b0, "add_5_3");
    endtask

    task automatic test_overflow();
        op4(4'd15, 4'd1, 1'b0, 4'd0, 1'b1, "add_15_1");
        op4(4'd0, 4'd0, 1'b1, 4'd1, 1'b0, "add_cin_only");
    endtask

    task automatic test_wide();
        op8(8'd255, 8'd255, 1'b1, 8'd255, 1'b1, "w8_max_cin1");
        op8(8'd255, 8'd255, 1'b0, 8'd254, 1'b1, "w8_max_cin0");
    endtask

    task automatic test_ignore_start();
        a4 = 4'd2; b4 = 4'd2; cin4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        checks++;
        if (busy4 !== 1'b1 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy: busy=%b done=%b, required busy=1 done=0", busy4, done4);
        end
        tick();
        tick();
        checks++;
        if (done4 !== 1'b1 || sum4 !== 4'd4 || cout4 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: done=%b sum=%0d cout=%b, required done=1 sum=4 cout=0", done4, sum4, cout4);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        a4 = 4'd5; b4 = 4'd3; cin4 = 1'b1; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 4'd0 || cout4 !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b sum=%0d cout=%b, required all 0", busy4, done4, sum4, cout4);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (done4 !== 1'b0 || busy4 !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet%0d: busy=%b done=%b, required 0 0", i, busy4, done4);
            end
        end
    endtask

    task automatic test_back_to_back();
        a4 = 4'd6; b4 = 4'd1; cin4 = 1'b0; start4 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (done4 !== 1'b1 || sum4 !== 4'd7 || cout4 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: done=%b sum=%0d cout=%b, required done=1 sum=7 cout=0", done4, sum4, cout4);
        end
        a4 = 4'd1; b4 = 4'd2;
        tick();
        start4 = 1'b0;
        checks++;
        if (busy4 !== 1'b1 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b done=%b, required busy=1 done=0", busy4, done4);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done4 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_early%0d: done=%b, required 0", i, done4);
            end
        end
        tick();
        checks++;
        if (done4 !== 1'b1 || sum4 !== 4'd3 || cout4 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: done=%b sum=%0d cout=%b, required done=1 sum=3 cout=0", done4, sum4, cout4);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_wide();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
